hash_result_arbiter: RTL and testbench
======================================

Name: hash_result_arbiter

Overview:
- Shares the single best-hash tracker between NUM_CORES parallel Skein hash cores.
- Round-robin selects one valid core result per cycle and holds it in a one-entry output stage.
- Presents the result to the tracker as a one-cycle new-hash pulse with bits-off and nonce.
- Stalls delivery while the transmitter's clear pulse is high, so no result is dropped by the tracker's reset.

Parameters:
- NUM_CORES, 4, number of requesting hash cores (2..16).
- NONCE_W, 256, nonce width.
- BITS_W, 10, bits-off width.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- core_valid_i  in  NUM_CORES  per-core result valid.
- core_bits_off_i  in  NUM_CORES*BITS_W  per-core bits-off; core k at [k*BITS_W +: BITS_W].
- core_nonce_i  in  NUM_CORES*NONCE_W  per-core nonce; core k at [k*NONCE_W +: NONCE_W].
- core_ready_o  out  NUM_CORES  one-hot accept; a transfer occurs on valid&ready.
- clear_i  in  1  transmitter clear, same signal that drives the tracker's reset_i.
- new_hash_o  out  1  one-cycle result pulse to the tracker.
- bits_off_o  out  BITS_W  bits-off of the held result.
- nonce_o  out  NONCE_W  nonce of the held result.
- grant_id_o  out  4  index of the core that produced the held result.
- accepted_cnt_o  out  CNT_W  count of results accepted from cores.

Behaviour:
- Reset values (reset_i high at an edge):
  - out_valid_q=0, rr_ptr=0, new_hash_o=0, bits_off_o=all ones, nonce_o=0.
  - grant_id_o=0, accepted_cnt_o=0, core_ready_o=0.
- Output stage states:
  - EMPTY: out_valid_q=0.
  - FULL: out_valid_q=1.
- Delivery:
  - new_hash_o = out_valid_q & ~clear_i (combinational from the register and clear_i).
  - The entry retires in any cycle where new_hash_o=1.
- Stall: while clear_i=1, new_hash_o=0 and the held entry plus all of its outputs stay unchanged. Delivery resumes the first cycle clear_i=0.
- Space: space = ~clear_i & (~out_valid_q | retire). This gives one result per cycle of sustained throughput.
- Arbitration:
  - Search starts at rr_ptr, ascending with wrap, for the first core with core_valid_i=1. Call it g.
  - core_ready_o[g] = space. All other ready bits are 0. With no valid core, all ready bits are 0.
  - Ready is asserted only toward a valid core.
- On transfer (valid&ready for core g):
  - Load bits_off_o, nonce_o and grant_id_o=g; set out_valid_q=1.
  - rr_ptr <= (g+1) mod NUM_CORES.
  - accepted_cnt_o increments, saturating at all ones.
- Retire without transfer: out_valid_q <= 0. Data outputs hold their last values.
- Retire and transfer in the same cycle: the new entry is loaded and out_valid_q stays 1.
- Latency: a result accepted at edge N pulses new_hash_o in the cycle after edge N, provided clear_i=0.
- Fairness: a continuously valid core is granted within NUM_CORES transfers.
- Core data must stay stable while its valid is high and unaccepted. The arbiter does not re-sample it.
- Reset mid-operation: the held entry is discarded with no pulse. Core-side results not yet accepted remain the cores' responsibility.
- clear_i and reset_i both high: reset wins.

Optional Feature:
- Macro: HASH_ARB_FILTER_EN.
- When defined:
  - Adds input best_bits_off_i [BITS_W] (the tracker's current best) and output dropped_cnt_o [CNT_W] (reset 0, saturating).
  - An accepted result with bits_off >= best_bits_off_i is still handshaken but not loaded. dropped_cnt_o increments and the output stage is unchanged.
  - accepted_cnt_o counts all handshakes, dropped ones included.
- When undefined: no extra ports; every accepted result is loaded.

Test Plan:
- Single core 1 valid, bits_off=400, nonce=0xABC, clear_i=0:
  - core_ready_o=4'b0010 in that cycle.
  - Next cycle new_hash_o=1, bits_off_o=400, grant_id_o=1.
  - accepted_cnt_o=1.
- All 4 cores held valid for 8 cycles from reset:
  - Grants are 0,1,2,3,0,1,2,3.
  - new_hash_o high on 8 consecutive cycles.
  - accepted_cnt_o=8.
- Output FULL with bits_off=123, clear_i high for 3 cycles:
  - new_hash_o=0 and core_ready_o=0 for those cycles.
  - bits_off_o stays 123.
  - Pulse occurs in the first cycle after clear_i falls.
- reset_i asserted while FULL and a core is valid:
  - Next cycle outputs are at reset values and new_hash_o=0.
  - rr_ptr=0, so core 0 is served first afterwards.
- Counter saturation with CNT_W=4: 20 transfers -> accepted_cnt_o=15.
- With HASH_ARB_FILTER_EN, best_bits_off_i=300, results 350 then 250:
  - 350 is dropped: dropped_cnt_o=1, no pulse.
  - 250 is delivered: pulse with bits_off_o=250.

Source files
------------

// File: rtl/hash_result_arbiter_if.sv
// Core-side request bus and tracker-side result bus of the hash result arbiter.
// The slave modport is the arbiter's view; the master modport is the cores/tracker view.
interface hash_result_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 256,
    parameter int BITS_W    = 10
);
    logic [NUM_CORES-1:0]         core_valid_i;
    logic [NUM_CORES*BITS_W-1:0]  core_bits_off_i;
    logic [NUM_CORES*NONCE_W-1:0] core_nonce_i;
    logic [NUM_CORES-1:0]         core_ready_o;
    logic                         new_hash_o;
    logic [BITS_W-1:0]            bits_off_o;
    logic [NONCE_W-1:0]           nonce_o;
    logic [3:0]                   grant_id_o;

    modport slave (
        input  core_valid_i, core_bits_off_i, core_nonce_i,
        output core_ready_o, new_hash_o, bits_off_o, nonce_o, grant_id_o
    );

    modport master (
        output core_valid_i, core_bits_off_i, core_nonce_i,
        input  core_ready_o, new_hash_o, bits_off_o, nonce_o, grant_id_o
    );
endinterface

// File: rtl/hash_result_arbiter.sv
// Round-robin arbiter sharing one best-hash tracker between NUM_CORES hash cores.
// Optional HASH_ARB_FILTER_EN drops results that cannot beat the tracker's current best.
module hash_result_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 256,
    parameter int BITS_W    = 10,
    parameter int CNT_W     = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                clear_i,
`ifdef HASH_ARB_FILTER_EN
    input  logic [BITS_W-1:0]   best_bits_off_i,
    output logic [CNT_W-1:0]    dropped_cnt_o,
`endif
    output logic [CNT_W-1:0]    accepted_cnt_o,
    hash_result_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_CORES);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BITS_W-1:0]  bits_off_q, bits_off_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [3:0]         grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   accepted_cnt_q, accepted_cnt_d;
`ifdef HASH_ARB_FILTER_EN
    logic [CNT_W-1:0]   dropped_cnt_q, dropped_cnt_d;
`endif

    logic [2*NUM_CORES-1:0] valid_dbl;
    logic [NUM_CORES-1:0]   valid_rot;
    logic [PTR_W:0]         grant_sum;
    logic [PTR_W-1:0]       grant_idx;
    logic                   found;
    logic                   retire, space, xfer, drop;
    logic [BITS_W-1:0]      sel_bits;
    logic [NONCE_W-1:0]     sel_nonce;

    // Rotating the request vector by rr_ptr turns the wrapped search into a fixed priority scan.
    always_comb begin
        valid_dbl = {bus.core_valid_i, bus.core_valid_i};
        valid_rot = NUM_CORES'(valid_dbl >> rr_ptr_q);
        found     = 1'b0;
        grant_sum = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && valid_rot[i]) begin
                found     = 1'b1;
                grant_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            end
        end
        if (grant_sum >= (PTR_W+1)'(NUM_CORES)) begin
            grant_sum = grant_sum - (PTR_W+1)'(NUM_CORES);
        end
        grant_idx = grant_sum[PTR_W-1:0];
        sel_bits  = BITS_W'(bus.core_bits_off_i >> (grant_idx * BITS_W));
        sel_nonce = NONCE_W'(bus.core_nonce_i >> (grant_idx * NONCE_W));
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        bits_off_d     = bits_off_q;
        nonce_d        = nonce_q;
        grant_id_d     = grant_id_q;
        accepted_cnt_d = accepted_cnt_q;
`ifdef HASH_ARB_FILTER_EN
        dropped_cnt_d  = dropped_cnt_q;
`endif

        // Gating with reset_i keeps a discarded entry from pulsing and a core from handshaking into reset.
        retire = (state_q == FULL) && !clear_i && !reset_i;
        space  = !clear_i && !reset_i && ((state_q == EMPTY) || retire);
        xfer   = found && space;
`ifdef HASH_ARB_FILTER_EN
        drop   = xfer && (sel_bits >= best_bits_off_i);
`else
        drop   = 1'b0;
`endif

        bus.new_hash_o   = retire;
        bus.core_ready_o = xfer ? (NUM_CORES'(1) << grant_idx) : '0;

        if (retire) begin
            state_d = EMPTY;
        end
        if (xfer) begin
            rr_ptr_d       = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
            accepted_cnt_d = (&accepted_cnt_q) ? accepted_cnt_q : accepted_cnt_q + 1'b1;
            if (!drop) begin
                state_d    = FULL;
                bits_off_d = sel_bits;
                nonce_d    = sel_nonce;
                grant_id_d = 4'(grant_idx);
            end
        end
`ifdef HASH_ARB_FILTER_EN
        if (drop) begin
            dropped_cnt_d = (&dropped_cnt_q) ? dropped_cnt_q : dropped_cnt_q + 1'b1;
        end
`endif
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= EMPTY;
            rr_ptr_q       <= '0;
            bits_off_q     <= '1;
            nonce_q        <= '0;
            grant_id_q     <= '0;
            accepted_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            bits_off_q     <= bits_off_d;
            nonce_q        <= nonce_d;
            grant_id_q     <= grant_id_d;
            accepted_cnt_q <= accepted_cnt_d;
        end
    end

`ifdef HASH_ARB_FILTER_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dropped_cnt_q <= '0;
        end else begin
            dropped_cnt_q <= dropped_cnt_d;
        end
    end

    assign dropped_cnt_o = dropped_cnt_q;
`endif

    assign bus.bits_off_o = bits_off_q;
    assign bus.nonce_o    = nonce_q;
    assign bus.grant_id_o = grant_id_q;
    assign accepted_cnt_o = accepted_cnt_q;
endmodule

// File: tb/tb_hash_result_arbiter.sv
// Self-checking bench for hash_result_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-free behavioural model of the arbitration rules.
`timescale 1ns/1ps
module tb_hash_result_arbiter;
    localparam int N  = 4;
    localparam int NW = 64;
    localparam int BW = 10;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic [CW-1:0] acc_cnt;
`ifdef HASH_ARB_FILTER_EN
    logic [BW-1:0] best_bits = '1;
    logic [CW-1:0] drop_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    hash_result_arbiter_if #(.NUM_CORES(N), .NONCE_W(NW), .BITS_W(BW)) bus ();

    hash_result_arbiter #(.NUM_CORES(N), .NONCE_W(NW), .BITS_W(BW), .CNT_W(CW)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .clear_i         (clear),
`ifdef HASH_ARB_FILTER_EN
        .best_bits_off_i (best_bits),
        .dropped_cnt_o   (drop_cnt),
`endif
        .accepted_cnt_o  (acc_cnt),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic v, input logic [BW-1:0] b, input logic [NW-1:0] n);
        bus.core_valid_i[k]            = v;
        bus.core_bits_off_i[k*BW +: BW] = b;
        bus.core_nonce_i[k*NW +: NW]    = n;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        bus.core_valid_i = '0;
        tick();
        reset = 1'b0;
    endtask

    // Behavioural model: one optional held result, a round-robin start index and two counters.
    logic          mv;
    logic [BW-1:0] mbits;
    logic [NW-1:0] mnonce;
    int            mgid, mptr, macc, mdrop, g, c;
    logic          m_new, m_space, m_drop;
    logic [N-1:0]  m_ready;
    logic [BW-1:0] m_b;

    initial begin
        mv = 1'b0; mbits = '1; mnonce = '0; mgid = 0; mptr = 0; macc = 0; mdrop = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            m_new   = mv && !clear && !reset;
            m_space = !clear && !reset && (!mv || m_new);
            g = -1;
            for (int i = 0; i < N; i++) begin
                c = (mptr + i) % N;
                if (g < 0 && bus.core_valid_i[c]) g = c;
            end
            m_ready = '0;
            if (g >= 0 && m_space) m_ready[g] = 1'b1;
            check("m_new_hash", NW'(bus.new_hash_o), NW'(m_new));
            check("m_ready",    NW'(bus.core_ready_o), NW'(m_ready));
            check("m_bits_off", NW'(bus.bits_off_o), NW'(mbits));
            check("m_nonce",    bus.nonce_o, mnonce);
            check("m_grant_id", NW'(bus.grant_id_o), NW'(mgid));
            check("m_accepted", NW'(acc_cnt), NW'(macc));
`ifdef HASH_ARB_FILTER_EN
            check("m_dropped",  NW'(drop_cnt), NW'(mdrop));
`endif
            @(posedge clk);
            if (reset) begin
                mv = 1'b0; mbits = '1; mnonce = '0; mgid = 0; mptr = 0; macc = 0; mdrop = 0;
            end else begin
                if (m_new) mv = 1'b0;
                if (m_ready != '0) begin
                    macc = (macc < CNT_MAX) ? macc + 1 : macc;
                    mptr = (g + 1) % N;
                    m_b  = bus.core_bits_off_i[g*BW +: BW];
                    m_drop = 1'b0;
`ifdef HASH_ARB_FILTER_EN
                    m_drop = (m_b >= best_bits);
`endif
                    if (m_drop) begin
                        mdrop = (mdrop < CNT_MAX) ? mdrop + 1 : mdrop;
                    end else begin
                        mv     = 1'b1;
                        mbits  = m_b;
                        mnonce = bus.core_nonce_i[g*NW +: NW];
                        mgid   = g;
                    end
                end
            end
        end
    end

    logic [N-1:0] hs;

    initial begin
        bus.core_valid_i    = '0;
        bus.core_bits_off_i = '0;
        bus.core_nonce_i    = '0;

        // Reset state, then a lone request from core 1.
        do_reset();
        @(negedge clk);
        check("rst_new_hash", NW'(bus.new_hash_o), 0);
        check("rst_bits_off", NW'(bus.bits_off_o), NW'(10'h3FF));
        check("rst_nonce",    bus.nonce_o, 0);
        check("rst_grant",    NW'(bus.grant_id_o), 0);
        check("rst_accepted", NW'(acc_cnt), 0);
        check("rst_ready",    NW'(bus.core_ready_o), 0);
        tick();
        set_core(1, 1'b1, 10'd400, 64'hABC);
        @(negedge clk);
        check("single_ready", NW'(bus.core_ready_o), NW'(4'b0010));
        tick();
        set_core(1, 1'b0, '0, '0);
        @(negedge clk);
        check("single_pulse",    NW'(bus.new_hash_o), 1);
        check("single_bits",     NW'(bus.bits_off_o), NW'(10'd400));
        check("single_grant",    NW'(bus.grant_id_o), 1);
        check("single_nonce",    bus.nonce_o, 64'hABC);
        check("single_accepted", NW'(acc_cnt), 1);
        tick();
        @(negedge clk);
        check("single_one_pulse", NW'(bus.new_hash_o), 0);

        // All cores continuously valid: strict rotation at full throughput.
        do_reset();
        for (int k = 0; k < N; k++) set_core(k, 1'b1, BW'(100 + k), NW'(k + 1));
        for (int cyc = 0; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc < 8) check("rr_ready", NW'(bus.core_ready_o), NW'(1 << (cyc % N)));
            if (cyc >= 1) begin
                check("rr_pulse", NW'(bus.new_hash_o), 1);
                check("rr_grant", NW'(bus.grant_id_o), NW'((cyc - 1) % N));
            end
            if (cyc == 8) check("rr_accepted", NW'(acc_cnt), 8);
            tick();
            if (cyc == 7) bus.core_valid_i = '0;
        end

        // Clear stalls a held result for three cycles.
        do_reset();
        set_core(2, 1'b1, 10'd123, 64'h55);
        @(negedge clk);
        check("clr_first_ready", NW'(bus.core_ready_o), NW'(4'b0100));
        tick();
        set_core(2, 1'b0, '0, '0);
        set_core(0, 1'b1, 10'd7, 64'h7);
        clear = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            check("clr_no_pulse", NW'(bus.new_hash_o), 0);
            check("clr_no_ready", NW'(bus.core_ready_o), 0);
            check("clr_hold_bits", NW'(bus.bits_off_o), NW'(10'd123));
            tick();
        end
        clear = 1'b0;
        @(negedge clk);
        check("clr_resume_pulse", NW'(bus.new_hash_o), 1);
        check("clr_resume_bits",  NW'(bus.bits_off_o), NW'(10'd123));
        check("clr_resume_grant", NW'(bus.grant_id_o), 2);
        check("clr_resume_ready", NW'(bus.core_ready_o), NW'(4'b0001));
        tick();
        set_core(0, 1'b0, '0, '0);

        // Reset while FULL: entry discarded, pointer back to core 0.
        do_reset();
        set_core(1, 1'b1, 10'd200, 64'h200);
        tick();
        set_core(1, 1'b0, '0, '0);
        set_core(0, 1'b1, 10'd11, 64'h11);
        set_core(2, 1'b1, 10'd22, 64'h22);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_no_pulse", NW'(bus.new_hash_o), 0);
        check("mid_rst_no_ready", NW'(bus.core_ready_o), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_no_pulse", NW'(bus.new_hash_o), 0);
        check("post_rst_bits",     NW'(bus.bits_off_o), NW'(10'h3FF));
        check("post_rst_accepted", NW'(acc_cnt), 0);
        check("post_rst_ready",    NW'(bus.core_ready_o), NW'(4'b0001));
        tick();
        bus.core_valid_i = '0;
        @(negedge clk);
        check("post_rst_grant", NW'(bus.grant_id_o), 0);
        check("post_rst_data",  NW'(bus.bits_off_o), NW'(10'd11));

        // Counter saturation: 20 transfers into a 4-bit counter.
        do_reset();
        set_core(0, 1'b1, 10'd5, 64'h5);
        repeat (10) tick();
        @(negedge clk);
        check("sat_mid", NW'(acc_cnt), 10);
        repeat (10) tick();
        set_core(0, 1'b0, '0, '0);
        @(negedge clk);
        check("sat_full", NW'(acc_cnt), 15);

`ifdef HASH_ARB_FILTER_EN
        // Filter: 350 is no better than 300 and is dropped; 250 is delivered.
        do_reset();
        best_bits = 10'd300;
        set_core(0, 1'b1, 10'd350, 64'h350);
        tick();
        set_core(0, 1'b0, '0, '0);
        @(negedge clk);
        check("flt_drop_no_pulse", NW'(bus.new_hash_o), 0);
        check("flt_drop_cnt",      NW'(drop_cnt), 1);
        check("flt_drop_accepted", NW'(acc_cnt), 1);
        tick();
        set_core(0, 1'b1, 10'd250, 64'h250);
        tick();
        set_core(0, 1'b0, '0, '0);
        @(negedge clk);
        check("flt_pass_pulse", NW'(bus.new_hash_o), 1);
        check("flt_pass_bits",  NW'(bus.bits_off_o), NW'(10'd250));
        check("flt_pass_drop",  NW'(drop_cnt), 1);
        tick();
        best_bits = '1;
`endif

        // Randomized traffic; cores hold their data until accepted.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            hs = bus.core_valid_i & bus.core_ready_o;
            tick();
            reset = ($urandom_range(0, 99) == 0);
            clear = ($urandom_range(0, 4) == 0);
`ifdef HASH_ARB_FILTER_EN
            if ($urandom_range(0, 19) == 0) best_bits = BW'($urandom_range(0, 1023));
`endif
            for (int k = 0; k < N; k++) begin
                if (hs[k] || !bus.core_valid_i[k]) begin
                    if ($urandom_range(0, 2) != 0)
                        set_core(k, 1'b1, BW'($urandom_range(0, 1023)), {$urandom, $urandom});
                    else
                        set_core(k, 1'b0, '0, '0);
                end
            end
        end
        reset = 1'b0;
        clear = 1'b0;
        bus.core_valid_i = '0;
        tick();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
